// File: rtl/writeback_buffer.sv
// Writeback buffer: queues ALU and load/mul results in acceptance order,
// drains one register-file write per cycle, and forwards pending results
// to two operand lookups.
module writeback_buffer #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_rd,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_rd,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_rd,
  output logic [DATA_W-1:0]          rf_wd,
  input  logic [ADDR_W-1:0]          fwd1_addr,
  output logic                       fwd1_hit,
  output logic [DATA_W-1:0]          fwd1_data,
  input  logic [ADDR_W-1:0]          fwd2_addr,
  output logic                       fwd2_hit,
  output logic [DATA_W-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic alu_store, mem_store, draining;
  ptr_t alu_slot, mem_slot;

  logic [ADDR_W-1:0] fwd_addr [2];
  logic              fwd_hit  [2];
  logic [DATA_W-1:0] fwd_data [2];

  // Readiness looks only at the registered occupancy; mem needs room for
  // a simultaneous ALU entry ahead of it.
  assign alu_ready = (count_q <= cnt_t'(DEPTH - 1));
  assign mem_ready = (count_q <= cnt_t'(DEPTH - 2));
  assign draining  = (count_q != '0);

  // Enqueue slot allocation and pointer/occupancy next state.
  // rd=0 transfers are accepted but never occupy a slot; the ALU entry is
  // always placed ahead of a same-cycle mem entry.
  always_comb begin
    alu_store = alu_valid && alu_ready && (alu_rd != '0);
    mem_store = mem_valid && mem_ready && (mem_rd != '0);
    alu_slot  = tail_q;
    mem_slot  = alu_store ? tail_q + ptr_t'(1) : tail_q;
    tail_d    = tail_q + ptr_t'(alu_store) + ptr_t'(mem_store);
    head_d    = draining ? head_q + ptr_t'(1) : head_q;
    count_d   = count_q + cnt_t'(alu_store) + cnt_t'(mem_store) - cnt_t'(draining);
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful inside the valid window.
  always_ff @(posedge clk) begin
    if (alu_store) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
    if (mem_store) begin
      rd_q[mem_slot]   <= mem_rd;
      data_q[mem_slot] <= mem_data;
    end
  end

  assign count = count_q;
  assign rf_we = draining;
  assign rf_rd = draining ? rd_q[head_q]   : '0;
  assign rf_wd = draining ? data_q[head_q] : '0;

  assign fwd_addr[0] = fwd1_addr;
  assign fwd_addr[1] = fwd2_addr;

  // Forwarding search: walk oldest to newest so the newest match wins.
  always_comb begin
    ptr_t idx;
    idx = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head_q + ptr_t'(i);
        if ((cnt_t'(i) < count_q) && (fwd_addr[p] != '0) && (rd_q[idx] == fwd_addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = data_q[idx];
        end
      end
    end
  end

  assign fwd1_hit  = fwd_hit[0];
  assign fwd1_data = fwd_data[0];
  assign fwd2_hit  = fwd_hit[1];
  assign fwd2_data = fwd_data[1];

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed self-checking bench for writeback_buffer (DEPTH=4, DATA_W=48).
module tb_writeback_buffer;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [47:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [47:0] mem_data;
  logic        mem_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [47:0] rf_wd;
  logic [4:0]  fwd1_addr;
  logic        fwd1_hit;
  logic [47:0] fwd1_data;
  logic [4:0]  fwd2_addr;
  logic        fwd2_hit;
  logic [47:0] fwd2_data;
  logic [2:0]  count;

  int tests_run;
  int tests_failed;

  logic [4:0]  wlog_rd [$];
  logic [47:0] wlog_wd [$];
  logic [47:0] rf_model [32];

  writeback_buffer #(.DATA_W(48), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .fwd1_addr(fwd1_addr), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_addr(fwd2_addr), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: captures every write the buffer issues.
  always @(posedge clk) begin
    if (rf_we) begin
      wlog_rd.push_back(rf_rd);
      wlog_wd.push_back(rf_wd);
      rf_model[rf_rd] = rf_wd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    fwd1_addr = 5'd5; fwd2_addr = 5'd0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
    tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_alu_ready got %0b want 1", alu_ready); end
    tests_run++; if (mem_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_mem_ready got %0b want 1", mem_ready); end
    tests_run++; if (fwd1_hit !== 1'b0 || fwd1_data !== 48'h0) begin tests_failed++; $display("FAIL reset_fwd1 got hit=%0b data=%h want 0/0", fwd1_hit, fwd1_data); end
    tests_run++; if (rf_rd !== 5'd0 || rf_wd !== 48'h0) begin tests_failed++; $display("FAIL reset_rf_bus got rd=%0d wd=%h want 0/0", rf_rd, rf_wd); end
  endtask

  task automatic test_alu_single();
    wlog_rd.delete(); wlog_wd.delete();
    fwd1_addr = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 48'h0000_0000_00AA;
    tests_run++; if (fwd1_hit !== 1'b0) begin tests_failed++; $display("FAIL alu_no_sameCycle_fwd got %0b want 0", fwd1_hit); end
    step();
    idle_inputs();
    tests_run++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 48'hAA) begin tests_failed++; $display("FAIL alu_write got we=%0b rd=%0d wd=%h want 1/3/aa", rf_we, rf_rd, rf_wd); end
    tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL alu_count1 got %0d want 1", count); end
    tests_run++; if (fwd1_hit !== 1'b1 || fwd1_data !== 48'hAA) begin tests_failed++; $display("FAIL alu_fwd_head got hit=%0b data=%h want 1/aa", fwd1_hit, fwd1_data); end
    step();
    tests_run++; if (count !== 3'd0 || rf_we !== 1'b0) begin tests_failed++; $display("FAIL alu_drained got count=%0d we=%0b want 0/0", count, rf_we); end
    tests_run++; if (fwd1_hit !== 1'b0) begin tests_failed++; $display("FAIL alu_fwd_gone got %0b want 0", fwd1_hit); end
    tests_run++; if (wlog_rd.size() != 1 || rf_model[3] !== 48'hAA) begin tests_failed++; $display("FAIL alu_rf_value got writes=%0d r3=%h want 1/aa", wlog_rd.size(), rf_model[3]); end
  endtask

  task automatic test_same_cycle();
    wlog_rd.delete(); wlog_wd.delete();
    fwd2_addr = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 48'h11;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 48'h22;
    step();
    idle_inputs();
    tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL same_count got %0d want 2", count); end
    tests_run++; if (fwd2_hit !== 1'b1 || fwd2_data !== 48'h22) begin tests_failed++; $display("FAIL same_fwd_newest got hit=%0b data=%h want 1/22", fwd2_hit, fwd2_data); end
    tests_run++; if (rf_rd !== 5'd7 || rf_wd !== 48'h11) begin tests_failed++; $display("FAIL same_first_write got rd=%0d wd=%h want 7/11", rf_rd, rf_wd); end
    step();
    tests_run++; if (rf_wd !== 48'h22 || fwd2_data !== 48'h22 || count !== 3'd1) begin tests_failed++; $display("FAIL same_second_write got wd=%h fwd=%h count=%0d want 22/22/1", rf_wd, fwd2_data, count); end
    step();
    tests_run++; if (wlog_wd.size() != 2 || rf_model[7] !== 48'h22) begin tests_failed++; $display("FAIL same_rf_final got writes=%0d r7=%h want 2/22", wlog_wd.size(), rf_model[7]); end
    else if (wlog_wd[0] !== 48'h11 || wlog_wd[1] !== 48'h22) begin tests_failed++; $display("FAIL same_order got %h,%h want 11,22", wlog_wd[0], wlog_wd[1]); end
  endtask

  task automatic test_back_to_back();
    int exp_cnt [15] = '{0, 2, 3, 3, 3, 3, 3, 3, 3, 2, 2, 2, 1, 0, 0};
    logic [4:0] exp_rd [12] = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd19, 5'd20};
    int ai, mi;
    ai = 0; mi = 0;
    wlog_rd.delete(); wlog_wd.delete();
    for (int cyc = 0; cyc < 15; cyc++) begin
      alu_valid = (ai < 8); alu_rd = 5'(ai + 1); alu_data = 48'(32'h100 + ai + 1);
      mem_valid = (mi < 4); mem_rd = 5'(17 + mi); mem_data = 48'(32'h200 + 17 + mi);
      #3;
      tests_run++; if (int'(count) != exp_cnt[cyc]) begin tests_failed++; $display("FAIL b2b_count[%0d] got %0d want %0d", cyc, count, exp_cnt[cyc]); end
      tests_run++; if (mem_ready !== (exp_cnt[cyc] <= 2)) begin tests_failed++; $display("FAIL b2b_mem_ready[%0d] got %0b want %0b", cyc, mem_ready, exp_cnt[cyc] <= 2); end
      tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_alu_ready[%0d] got %0b want 1", cyc, alu_ready); end
      if (alu_valid && alu_ready) ai++;
      if (mem_valid && mem_ready) mi++;
      step();
    end
    idle_inputs();
    tests_run++; if (wlog_rd.size() != 12) begin tests_failed++; $display("FAIL b2b_write_count got %0d want 12", wlog_rd.size()); end
    else begin
      for (int k = 0; k < 12; k++) begin
        logic [47:0] want_wd;
        want_wd = (exp_rd[k] >= 5'd17) ? 48'h200 + 48'(exp_rd[k]) : 48'h100 + 48'(exp_rd[k]);
        tests_run++; if (wlog_rd[k] !== exp_rd[k] || wlog_wd[k] !== want_wd) begin tests_failed++; $display("FAIL b2b_order[%0d] got rd=%0d wd=%h want rd=%0d wd=%h", k, wlog_rd[k], wlog_wd[k], exp_rd[k], want_wd); end
      end
    end
  endtask

  task automatic test_rd_zero();
    wlog_rd.delete(); wlog_wd.delete();
    fwd1_addr = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 48'hFF;
    tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL rd0_ready got %0b want 1", alu_ready); end
    step();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (count !== 3'd0 || rf_we !== 1'b0) begin tests_failed++; $display("FAIL rd0_not_stored[%0d] got count=%0d we=%0b want 0/0", k, count, rf_we); end
      step();
    end
    tests_run++; if (fwd1_hit !== 1'b0 || fwd1_data !== 48'h0) begin tests_failed++; $display("FAIL rd0_fwd got hit=%0b data=%h want 0/0", fwd1_hit, fwd1_data); end
    tests_run++; if (wlog_rd.size() != 0) begin tests_failed++; $display("FAIL rd0_writes got %0d want 0", wlog_rd.size()); end
  endtask

  task automatic test_reset_mid();
    fwd1_addr = 5'd11; fwd2_addr = 5'd13;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 48'hA10;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 48'hB11;
    step();
    alu_rd = 5'd12; alu_data = 48'hA12;
    mem_rd = 5'd13; mem_data = 48'hB13;
    step();
    idle_inputs();
    tests_run++; if (count !== 3'd3 || rf_rd !== 5'd11) begin tests_failed++; $display("FAIL mid_fill got count=%0d rd=%0d want 3/11", count, rf_rd); end
    tests_run++; if (fwd1_data !== 48'hB11 || fwd2_data !== 48'hB13 || !fwd1_hit || !fwd2_hit) begin tests_failed++; $display("FAIL mid_fwd got %h/%h want b11/b13", fwd1_data, fwd2_data); end
    #2;
    reset = 1'b0;
    #1;
    tests_run++; if (rf_we !== 1'b0 || count !== 3'd0) begin tests_failed++; $display("FAIL mid_async_clear got we=%0b count=%0d want 0/0", rf_we, count); end
    tests_run++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin tests_failed++; $display("FAIL mid_fwd_clear got %0b/%0b want 0/0", fwd1_hit, fwd2_hit); end
    #2;
    reset = 1'b1;
    wlog_rd.delete(); wlog_wd.delete();
    repeat (3) step();
    tests_run++; if (wlog_rd.size() != 0 || count !== 3'd0) begin tests_failed++; $display("FAIL mid_no_stale got writes=%0d count=%0d want 0/0", wlog_rd.size(), count); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    test_reset();
    test_alu_single();
    test_same_cycle();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
